// File: rtl/word_unpacker.sv
// word_unpacker: pops one IN_WIDTH-bit word through an empty/rd_en interface
// and re-emits it as N = IN_WIDTH/OUT_WIDTH chunks through the same style of
// empty/rd_en interface, so the next stage reads chunks as if from a FIFO.
// Chunk order is set by MSB_FIRST (0: low chunk first, 1: top chunk first).
// Optional feature: define WORD_UNPACKER_PREFETCH_EN to add a one-word hold
// register that prefetches the next word while the current one drains,
// removing the idle bubble between words.
module word_unpacker #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IN_WIDTH-1:0]  din,
  input  logic                 din_empty,
  output logic                 din_rd_en,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 last,
  output logic                 empty,
  input  logic                 rd_en
);

  localparam int N  = IN_WIDTH / OUT_WIDTH;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OUT  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nxt;
  logic [IN_WIDTH-1:0] sreg;
  logic [IN_WIDTH-1:0] sreg_nxt;
  logic                at_last;
  logic                consume;

`ifdef WORD_UNPACKER_PREFETCH_EN
  logic [IN_WIDTH-1:0] hold;
  logic [IN_WIDTH-1:0] hold_nxt;
  logic                hold_full;
  logic                hold_full_nxt;
`endif

  // The shift register always presents the current chunk at its output end,
  // so dout comes straight from flops and is zero after reset.
  function automatic logic [IN_WIDTH-1:0] advance(input logic [IN_WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w << OUT_WIDTH;
    end else begin
      return w >> OUT_WIDTH;
    end
  endfunction

  assign at_last = (cnt == CNT_LAST);
  assign empty   = (state != OUT);
  assign last    = (state == OUT) && at_last;
  assign consume = (state == OUT) && rd_en;

  if (MSB_FIRST) begin : g_msb_first
    assign dout = sreg[IN_WIDTH-1 -: OUT_WIDTH];
  end else begin : g_lsb_first
    assign dout = sreg[OUT_WIDTH-1:0];
  end

  // Next-state, upstream pop and datapath updates; rd_en only matters in OUT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    din_rd_en = 1'b0;
`ifdef WORD_UNPACKER_PREFETCH_EN
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    din_rd_en     = ~din_empty & ~hold_full;
    case (state)
      IDLE: begin
        if (hold_full) begin
          sreg_nxt      = hold;
          cnt_nxt       = '0;
          hold_full_nxt = 1'b0;
          state_nxt     = OUT;
        end else if (din_rd_en) begin
          sreg_nxt  = din;
          cnt_nxt   = '0;
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (din_rd_en) begin
          hold_nxt      = din;
          hold_full_nxt = 1'b1;
        end
        if (consume) begin
          if (!at_last) begin
            cnt_nxt  = cnt + CW'(1);
            sreg_nxt = advance(sreg);
          end else if (hold_full) begin
            sreg_nxt      = hold;
            cnt_nxt       = '0;
            hold_full_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
`else
    din_rd_en = (state == IDLE) & ~din_empty;
    case (state)
      IDLE: begin
        if (din_rd_en) begin
          sreg_nxt  = din;
          cnt_nxt   = '0;
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (consume) begin
          if (!at_last) begin
            cnt_nxt  = cnt + CW'(1);
            sreg_nxt = advance(sreg);
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
`endif
  end

  // State register; reset drops any partially emitted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Chunk counter and shift register (plus hold buffer when prefetching).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sreg <= '0;
`ifdef WORD_UNPACKER_PREFETCH_EN
      hold      <= '0;
      hold_full <= 1'b0;
`endif
    end else begin
      cnt  <= cnt_nxt;
      sreg <= sreg_nxt;
`ifdef WORD_UNPACKER_PREFETCH_EN
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_word_unpacker.sv
// tb_word_unpacker: drives two word_unpacker instances (MSB_FIRST=0 and 1)
// from one upstream word queue and checks their chunk streams against a
// scoreboard filled from each popped word.
module tb_word_unpacker;

  localparam int IW = 64;
  localparam int OW = 16;
  localparam int N  = IW / OW;
`ifdef WORD_UNPACKER_PREFETCH_EN
  localparam int B2B_SPAN = 8;
`else
  localparam int B2B_SPAN = 9;
`endif

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
  } chunk_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [IW-1:0]       din = '0;
  logic                din_empty = 1'b1;
  logic                rd_en = 1'b0;
  logic [1:0]          din_rd_en_v;
  logic [1:0][OW-1:0]  dout_v;
  logic [1:0]          last_v;
  logic [1:0]          empty_v;

  logic [IW-1:0] upq[$];
  chunk_t        sb0[$];
  chunk_t        sb1[$];
  logic [OW-1:0] log0[$];
  logic [OW-1:0] log1[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int consumed = 0;
  int pops = 0;
  int firstCyc = -1;
  int lastCyc = -1;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    word_unpacker #(
      .IN_WIDTH (IW),
      .OUT_WIDTH(OW),
      .MSB_FIRST(g)
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (din),
      .din_empty(din_empty),
      .din_rd_en(din_rd_en_v[g]),
      .dout     (dout_v[g]),
      .last     (last_v[g]),
      .empty    (empty_v[g]),
      .rd_en    (rd_en)
    );
  end

  function automatic logic [OW-1:0] chunkOf(input logic [IW-1:0] w, input int k, input bit msb);
    int idx;
    idx = msb ? (N - 1 - k) : k;
    return w[idx*OW +: OW];
  endfunction

  task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushWord(input logic [IW-1:0] w);
    for (int k = 0; k < N; k++) begin
      sb0.push_back('{data: chunkOf(w, k, 1'b0), last: (k == N - 1)});
      sb1.push_back('{data: chunkOf(w, k, 1'b1), last: (k == N - 1)});
    end
  endtask

  // Called #1 after the falling edge with inputs settled for the next rising edge.
  task automatic checkOutput();
    if (!empty_v[0]) begin
      compare("sb0_has_chunk", sb0.size() > 0, 1);
      if (sb0.size() > 0) begin
        compare("dout0", dout_v[0], sb0[0].data);
        compare("last0", last_v[0], sb0[0].last);
      end
    end
    if (!empty_v[1]) begin
      compare("sb1_has_chunk", sb1.size() > 0, 1);
      if (sb1.size() > 0) begin
        compare("dout1", dout_v[1], sb1[0].data);
        compare("last1", last_v[1], sb1[0].last);
      end
    end
`ifdef WORD_UNPACKER_PREFETCH_EN
    if (sb0.size() == 0) compare("empty0_idle", empty_v[0], 1);
    if (sb1.size() == 0) compare("empty1_idle", empty_v[1], 1);
    compare("din_rd_en0_legal", din_rd_en_v[0] && (din_empty || sb0.size() > N), 0);
    compare("din_rd_en1_legal", din_rd_en_v[1] && (din_empty || sb1.size() > N), 0);
`else
    compare("empty0", empty_v[0], sb0.size() == 0);
    compare("empty1", empty_v[1], sb1.size() == 0);
    compare("din_rd_en0", din_rd_en_v[0], !din_empty && sb0.size() == 0);
    compare("din_rd_en1", din_rd_en_v[1], !din_empty && sb1.size() == 0);
`endif
    if (rd_en && !empty_v[0] && sb0.size() > 0) begin
      log0.push_back(sb0[0].data);
      void'(sb0.pop_front());
      consumed++;
      if (firstCyc < 0) firstCyc = cyc;
      lastCyc = cyc;
    end
    if (rd_en && !empty_v[1] && sb1.size() > 0) begin
      log1.push_back(sb1[0].data);
      void'(sb1.pop_front());
    end
    if (din_rd_en_v[0] && upq.size() > 0) begin
      pushWord(upq.pop_front());
      pops++;
    end
  endtask

  task automatic applyStimulus(input logic rd);
    @(negedge clk);
    cyc++;
    rd_en = rd;
    din_empty = (upq.size() == 0);
    din = din_empty ? '0 : upq[0];
    #1;
    checkOutput();
  endtask

  task automatic drain(input int target, input int budget);
    int n;
    n = 0;
    while (consumed < target && n < budget) begin
      applyStimulus(1'b1);
      n++;
    end
    compare("drain_done", consumed >= target, 1);
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      compare("rst_empty", empty_v[i], 1);
      compare("rst_dout", dout_v[i], 0);
      compare("rst_last", last_v[i], 0);
      compare("rst_din_rd_en", din_rd_en_v[i], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single word, rd_en held high
    $display("[TB] single word");
    upq.push_back(64'h1111_2222_3333_4444);
    drain(consumed + 4, 12);
    compare("single_pops", pops, 1);
    compare("w1_lsb_c0", log0[0], 16'h4444);
    compare("w1_lsb_c1", log0[1], 16'h3333);
    compare("w1_lsb_c2", log0[2], 16'h2222);
    compare("w1_lsb_c3", log0[3], 16'h1111);
    compare("w1_msb_c0", log1[0], 16'h1111);
    compare("w1_msb_c3", log1[3], 16'h4444);
    applyStimulus(1'b1);
    compare("single_empty_after", empty_v[0], 1);

    // Starvation, with a spurious read on the last starved cycle
    $display("[TB] starvation and stall");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i == 9);
      compare("starve_rd_en", din_rd_en_v[0], 0);
      compare("starve_empty", empty_v[0], 1);
    end
    upq.push_back(64'h1111_2222_3333_4444);
    applyStimulus(1'b0);
    compare("pop_on_fall", din_rd_en_v[0], 1);
    log0.delete();
    log1.delete();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0);
      compare("stall_dout0", dout_v[0], 16'h4444);
      compare("stall_last0", last_v[0], 0);
      compare("stall_dout1", dout_v[1], 16'h1111);
      compare("stall_empty", empty_v[0], 0);
    end
    drain(consumed + 4, 12);
    compare("stall_c0", log0[0], 16'h4444);
    compare("stall_c3", log0[3], 16'h1111);
    compare("stall_count", log0.size(), 4);

    // Back-to-back words with rd_en held high
    $display("[TB] back-to-back");
    firstCyc = -1;
    upq.push_back(64'hA);
    upq.push_back(64'hB);
    drain(consumed + 8, 30);
    compare("b2b_span", lastCyc - firstCyc + 1, B2B_SPAN);
    applyStimulus(1'b0);
    compare("b2b_idle", empty_v[0], 1);

    // Reset in the middle of a word
    $display("[TB] reset mid-word");
    upq.push_back(64'h1111_2222_3333_4444);
    drain(consumed + 2, 10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      compare("midrst_empty", empty_v[i], 1);
      compare("midrst_dout", dout_v[i], 0);
      compare("midrst_last", last_v[i], 0);
    end
    sb0.delete();
    sb1.delete();
    upq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    log0.delete();
    log1.delete();
    upq.push_back(64'h5555_6666_7777_8888);
    drain(consumed + 4, 12);
    compare("after_rst_c0", log0[0], 16'h8888);
    compare("after_rst_c3", log0[3], 16'h5555);
    compare("after_rst_msb_c0", log1[0], 16'h5555);
    compare("after_rst_count", log0.size(), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_unpacker.md
Name: word_unpacker

Overview:
- Read-side consumer placed directly downstream of the clock-domain-crossing register, in the rd_clk domain.
- Pops one wide word through an empty/rd_en interface and re-emits it as IN_WIDTH/OUT_WIDTH narrower chunks.
- Its output uses the same empty/rd_en FIFO-style interface, so the next core-side stage reads chunks exactly as it would read a FIFO.

Parameters:
- IN_WIDTH, 64, width of the input word; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 16, width of each output chunk; N = IN_WIDTH/OUT_WIDTH must be at least 2.
- MSB_FIRST, 0, chunk order: 0 emits bits [OUT_WIDTH-1:0] first; 1 emits the top chunk first.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- din  input  IN_WIDTH  input word; valid while din_empty=0.
- din_empty  input  1  upstream has no word available.
- din_rd_en  output  1  pops the upstream word in the current cycle.
- dout  output  OUT_WIDTH  current chunk; registered.
- last  output  1  dout is the final chunk of its word; qualified by empty=0.
- empty  output  1  no chunk available.
- rd_en  input  1  downstream consumes dout this cycle.

Behaviour:
- Reset, asserted asynchronously:
  - state=IDLE, cnt=0, shift register=0, dout=0, last=0, empty=1, din_rd_en=0.
  - Reset takes effect mid-word: the partially emitted word is discarded, and any word popped in the reset cycle is lost.
- din_rd_en is combinational from registered state and din_empty only. It never depends on rd_en in the non-prefetch build.
- State IDLE:
  - empty=1.
  - din_rd_en = ~din_empty.
  - On din_rd_en: capture din into the shift register, cnt<=0, go to OUT.
- State OUT:
  - empty=0.
  - dout = chunk cnt, in the order set by MSB_FIRST.
  - last = (cnt==N-1).
  - On rd_en with cnt<N-1: cnt<=cnt+1 and the shift register advances by OUT_WIDTH.
  - On rd_en with cnt==N-1: go to IDLE.
- Latency: word popped at cycle t, first chunk visible (empty=0) at t+1.
- Throughput without prefetch: N chunks per N+1 cycles. There is a one-cycle bubble in IDLE between words.
- rd_en while empty=1 is ignored: no state change, no error flag.
- rd_en held high continuously emits one chunk per cycle.
- dout and last hold their values while rd_en=0; no chunk is ever skipped or repeated.
- cnt width is clog2(N). cnt never exceeds N-1. There is no wrap-around other than the return to IDLE.

Optional Feature:
- Macro: WORD_UNPACKER_PREFETCH_EN.
- Defined:
  - Adds a hold register and a hold_full flag.
  - din_rd_en = ~din_empty & ~hold_full, so the next word is prefetched while the current word is being emitted.
  - When the last chunk is consumed (rd_en & last) and hold_full=1, the shift register loads from hold in the same cycle and stays in OUT, with no bubble.
  - hold_full clears unless a new pop occurs in that same cycle.
  - If the shift register is idle and hold_full=1, load from hold on the next edge.
  - Sustained throughput is N chunks per N cycles.
  - Reset also clears hold_full.
- Undefined: the behaviour is exactly as described above, with no hold register.

Test Plan:
- Single word, defaults (IN_WIDTH=64, OUT_WIDTH=16, MSB_FIRST=0):
  - Stimulus: din=64'h1111_2222_3333_4444 with din_empty=0 for one pop, rd_en=1 held.
  - Response: dout = 16'h4444, 3333, 2222, 1111 on consecutive cycles; last=1 only with 1111; din_rd_en pulses exactly once; empty=1 after.
- MSB_FIRST=1, same word:
  - Response: dout = 1111, 2222, 3333, 4444; last=1 with 4444.
- Back-to-back words, rd_en=1 held:
  - Stimulus: words A=64'hA, B=64'hB, both available.
  - Response without the macro: 8 chunks in 9 cycles, with one empty=1 cycle between A's last chunk and B's first.
  - Response with WORD_UNPACKER_PREFETCH_EN: 8 chunks in 8 consecutive cycles, with no empty gap.
- Stall and spurious read:
  - Stimulus: rd_en=1 while empty=1, then rd_en=0 for 5 cycles after the first chunk.
  - Response: no state change on the spurious read; dout stays 16'h4444 and last=0 throughout the stall; the sequence resumes correctly.
- Reset mid-word:
  - Stimulus: assert rst_n=0 after 2 chunks have been read.
  - Response: empty=1, dout=0, last=0 immediately (asynchronously).
  - After release with new word 64'h5555_6666_7777_8888: first chunk is 8888; no stale chunks appear.
- Upstream starvation:
  - Stimulus: din_empty=1 for 10 cycles.
  - Response: din_rd_en=0 and empty=1 throughout; the first word is popped in the same cycle din_empty falls.
